rat_io_peripheral: RTL and testbench

- Peripheral-side responder for the RAT MCU I/O bus. It decodes MCU output strobes (OUT_PORT/PORT_ID/IO_STRB) into LED, seven-segment and timer registers.
- It returns read data on IN_PORT from switches, buttons and status.
- It generates the MCU interrupt (INT_CU) from a programmable 16-bit timer and a button-0 rising edge.
- Sits at top level beside RAT_MCU; board I/O attaches here.

---
 rtl/rat_io_peripheral.sv | 126 ++++++++++++
 tb/tb_rat_io_peripheral.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rat_io_peripheral.sv
// RAT MCU I/O responder: decodes OUT strobes into LED, seven-segment and
// timer registers, muxes read data onto IN_PORT, and raises INT_CU from a
// reloadable down-counting timer and a button-0 rising edge.
module rat_io_peripheral #(
  parameter logic [7:0] LED_ID       = 8'h40,
  parameter logic [7:0] SSEG_ID      = 8'h81,
  parameter logic [7:0] SWITCH_ID    = 8'hFF,
  parameter logic [7:0] BTN_ID       = 8'h9A,
  parameter logic [7:0] TMR_LO_ID    = 8'hB0,
  parameter logic [7:0] TMR_HI_ID    = 8'hB1,
  parameter logic [7:0] CTRL_ID      = 8'hB2,
  parameter logic [7:0] ACK_ID       = 8'hB3,
  parameter logic [7:0] CNT_ID       = 8'hB4,
  parameter int         TMR_PRESCALE = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] OUT_PORT,
  input  logic [7:0] PORT_ID,
  input  logic       IO_STRB,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  output logic [7:0] IN_PORT,
  output logic       INT_CU,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_VAL
);

  localparam logic [15:0] PS_LAST = 16'(TMR_PRESCALE - 1);

  logic [7:0]  leds_reg, sseg_reg, lo_stage_reg;
  logic [15:0] reload_reg, count_reg, count_next;
  logic [15:0] presc_reg, presc_next;
  logic [2:0]  ctrl_reg;
  logic [1:0]  pending_reg, pending_next;
  logic [3:0]  btn_meta_reg, btn_sync_reg;
  logic        btn_prev_reg;
  logic        int_reg;

  // Write decode: a strobe with an unmatched ID selects nothing
  logic wr_led, wr_sseg, wr_lo, wr_hi, wr_ctrl, wr_ack;
  assign wr_led  = IO_STRB && (PORT_ID == LED_ID);
  assign wr_sseg = IO_STRB && (PORT_ID == SSEG_ID);
  assign wr_lo   = IO_STRB && (PORT_ID == TMR_LO_ID);
  assign wr_hi   = IO_STRB && (PORT_ID == TMR_HI_ID);
  assign wr_ctrl = IO_STRB && (PORT_ID == CTRL_ID);
  assign wr_ack  = IO_STRB && (PORT_ID == ACK_ID);

  // Event sources; a reload commit suppresses the coincident timer event
  logic       tick, timer_set, btn_rise;
  logic [1:0] pend_set, pend_clr;
  assign tick      = ctrl_reg[0] && (presc_reg == PS_LAST);
  assign timer_set = tick && (count_reg == 16'd0) && !wr_hi;
  assign btn_rise  = btn_sync_reg[0] & ~btn_prev_reg;
  assign pend_set  = {btn_rise, timer_set};
  assign pend_clr  = wr_ack ? OUT_PORT[1:0] : 2'b00;

  // Set has priority over a same-cycle acknowledge of the same bit
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pending
      assign pending_next[gi] = pend_set[gi] | (pending_reg[gi] & ~pend_clr[gi]);
    end
  endgenerate

  // Timer count and prescaler next-state
  always_comb begin
    count_next = count_reg;
    presc_next = presc_reg;
    if (wr_hi) begin
      count_next = {OUT_PORT, lo_stage_reg};
      presc_next = 16'd0;
    end else begin
      if (tick)
        count_next = (count_reg == 16'd0) ? reload_reg : count_reg - 16'd1;
      if (wr_ctrl && !OUT_PORT[0])
        presc_next = 16'd0;
      else if (ctrl_reg[0])
        presc_next = (presc_reg == PS_LAST) ? 16'd0 : presc_reg + 16'd1;
    end
  end

  // All architectural state; reset beats any same-cycle strobe
  always_ff @(posedge CLK) begin
    if (RESET) begin
      leds_reg     <= '0;
      sseg_reg     <= '0;
      lo_stage_reg <= '0;
      reload_reg   <= '0;
      count_reg    <= '0;
      presc_reg    <= '0;
      ctrl_reg     <= '0;
      pending_reg  <= '0;
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
      btn_prev_reg <= 1'b0;
      int_reg      <= 1'b0;
    end else begin
      if (wr_led)  leds_reg     <= OUT_PORT;
      if (wr_sseg) sseg_reg     <= OUT_PORT;
      if (wr_lo)   lo_stage_reg <= OUT_PORT;
      if (wr_hi)   reload_reg   <= {OUT_PORT, lo_stage_reg};
      if (wr_ctrl) ctrl_reg     <= OUT_PORT[2:0];
      count_reg    <= count_next;
      presc_reg    <= presc_next;
      pending_reg  <= pending_next;
      btn_meta_reg <= BUTTONS;
      btn_sync_reg <= btn_meta_reg;
      btn_prev_reg <= btn_sync_reg[0];
      int_reg      <= (pending_reg[0] & ctrl_reg[1]) | (pending_reg[1] & ctrl_reg[2]);
    end
  end

  // Combinational read mux, no strobe required
  always_comb begin
    IN_PORT = 8'h00;
    if (PORT_ID == SWITCH_ID)    IN_PORT = SWITCHES;
    else if (PORT_ID == BTN_ID)  IN_PORT = {4'h0, btn_sync_reg};
    else if (PORT_ID == CTRL_ID) IN_PORT = {3'b000, pending_reg, ctrl_reg};
    else if (PORT_ID == CNT_ID)  IN_PORT = count_reg[7:0];
  end

  assign LEDS     = leds_reg;
  assign SSEG_VAL = sseg_reg;
  assign INT_CU   = int_reg;

endmodule

// File: tb/tb_rat_io_peripheral.sv
// Directed bench for rat_io_peripheral: inputs change at the falling edge,
// outputs are sampled after the falling edge, one task per feature.
module tb_rat_io_peripheral;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] OUT_PORT, PORT_ID, SWITCHES, IN_PORT, LEDS, SSEG_VAL;
  logic       IO_STRB, INT_CU;
  logic [3:0] BUTTONS;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  rat_io_peripheral dut (
    .CLK(CLK), .RESET(RESET), .OUT_PORT(OUT_PORT), .PORT_ID(PORT_ID),
    .IO_STRB(IO_STRB), .SWITCHES(SWITCHES), .BUTTONS(BUTTONS),
    .IN_PORT(IN_PORT), .INT_CU(INT_CU), .LEDS(LEDS), .SSEG_VAL(SSEG_VAL)
  );

  // One OUT instruction: strobe across exactly one rising edge
  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    @(negedge CLK);
    IO_STRB  = 1'b0;
    $display("write id=%02h data=%02h t=%0t", id, data, $time);
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] d);
    PORT_ID = id;
    #1;
    d = IN_PORT;
    $display("read  id=%02h data=%02h t=%0t", id, d, $time);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    RESET = 1'b1; IO_STRB = 1'b1; PORT_ID = 8'h40; OUT_PORT = 8'hC3;
    repeat (3) @(negedge CLK);
    PORT_ID = 8'h81; OUT_PORT = 8'h5A;
    @(negedge CLK);
    IO_STRB = 1'b0;
    n_checks++; if (LEDS !== 8'h00) begin n_fail++; $display("FAIL reset_leds got=%02h exp=00", LEDS); end
    n_checks++; if (SSEG_VAL !== 8'h00) begin n_fail++; $display("FAIL reset_sseg got=%02h exp=00", SSEG_VAL); end
    n_checks++; if (INT_CU !== 1'b0) begin n_fail++; $display("FAIL reset_int got=%0b exp=0", INT_CU); end
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status got=%02h exp=00", d); end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_port_decode;
    wr(8'h40, 8'hA5);
    wr(8'h81, 8'h3C);
    n_checks++; if (LEDS !== 8'hA5) begin n_fail++; $display("FAIL dec_leds got=%02h exp=a5", LEDS); end
    n_checks++; if (SSEG_VAL !== 8'h3C) begin n_fail++; $display("FAIL dec_sseg got=%02h exp=3c", SSEG_VAL); end
    wr(8'h41, 8'h77);
    n_checks++; if (LEDS !== 8'hA5 || SSEG_VAL !== 8'h3C) begin n_fail++; $display("FAIL dec_unmatched got=%02h/%02h exp=a5/3c", LEDS, SSEG_VAL); end
    PORT_ID = 8'h40; OUT_PORT = 8'h11; IO_STRB = 1'b0;
    @(negedge CLK);
    n_checks++; if (LEDS !== 8'hA5) begin n_fail++; $display("FAIL dec_nostrobe got=%02h exp=a5", LEDS); end
  endtask

  task automatic test_read_mux;
    logic [7:0] d;
    SWITCHES = 8'h0A;
    rd(8'hFF, d);
    n_checks++; if (d !== 8'h0A) begin n_fail++; $display("FAIL rd_switch got=%02h exp=0a", d); end
    SWITCHES = 8'hC7;
    rd(8'hFF, d);
    n_checks++; if (d !== 8'hC7) begin n_fail++; $display("FAIL rd_switch2 got=%02h exp=c7", d); end
    rd(8'h55, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rd_other got=%02h exp=00", d); end
    rd(8'h9A, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rd_btn_idle got=%02h exp=00", d); end
  endtask

  task automatic test_timer;
    logic [7:0] d;
    wr(8'hB0, 8'h04);
    wr(8'hB1, 8'h00);
    rd(8'hB4, d);
    n_checks++; if (d !== 8'h04) begin n_fail++; $display("FAIL tmr_loaded got=%02h exp=04", d); end
    wr(8'hB2, 8'h03);
    rd(8'hB4, d);
    n_checks++; if (d !== 8'h04) begin n_fail++; $display("FAIL tmr_cnt4 got=%02h exp=04", d); end
    for (int k = 3; k >= 0; k--) begin
      @(negedge CLK);
      rd(8'hB4, d);
      n_checks++; if (d !== 8'(k)) begin n_fail++; $display("FAIL tmr_cnt got=%02h exp=%02h", d, 8'(k)); end
    end
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL tmr_not_yet got=%02h exp=03", d); end
    @(negedge CLK);
    rd(8'hB4, d);
    n_checks++; if (d !== 8'h04) begin n_fail++; $display("FAIL tmr_reload got=%02h exp=04", d); end
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h0B) begin n_fail++; $display("FAIL tmr_pending got=%02h exp=0b", d); end
    n_checks++; if (INT_CU !== 1'b0) begin n_fail++; $display("FAIL tmr_int_early got=%0b exp=0", INT_CU); end
    @(negedge CLK);
    n_checks++; if (INT_CU !== 1'b1) begin n_fail++; $display("FAIL tmr_int got=%0b exp=1", INT_CU); end
  endtask

  task automatic test_timer_ack;
    logic [7:0] d;
    wr(8'hB3, 8'h01);
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL ack_clr got=%02h exp=03", d); end
    @(negedge CLK);
    n_checks++; if (INT_CU !== 1'b0) begin n_fail++; $display("FAIL ack_int_low got=%0b exp=0", INT_CU); end
    @(negedge CLK);
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL ack_wait got=%02h exp=03", d); end
    @(negedge CLK);
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h0B) begin n_fail++; $display("FAIL ack_reset got=%02h exp=0b", d); end
    @(negedge CLK);
    n_checks++; if (INT_CU !== 1'b1) begin n_fail++; $display("FAIL ack_reassert got=%0b exp=1", INT_CU); end
    wr(8'hB3, 8'h01);
    @(negedge CLK);
    @(negedge CLK);
    rd(8'hB4, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL ack_cnt0 got=%02h exp=00", d); end
    wr(8'hB3, 8'h01);
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h0B) begin n_fail++; $display("FAIL ack_set_wins got=%02h exp=0b", d); end
    wr(8'hB2, 8'h00);
    wr(8'hB3, 8'h01);
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL ack_disable got=%02h exp=00", d); end
    repeat (2) @(negedge CLK);
    rd(8'hB4, d);
    n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL ack_hold got=%02h exp=03", d); end
    n_checks++; if (INT_CU !== 1'b0) begin n_fail++; $display("FAIL ack_off_int got=%0b exp=0", INT_CU); end
  endtask

  task automatic test_hi_on_tick;
    logic [7:0] d;
    wr(8'hB0, 8'h02);
    wr(8'hB1, 8'h00);
    wr(8'hB2, 8'h01);
    repeat (2) @(negedge CLK);
    rd(8'hB4, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL hi_pre got=%02h exp=00", d); end
    wr(8'hB1, 8'h00);
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL hi_no_set got=%02h exp=01", d); end
    rd(8'hB4, d);
    n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL hi_reload got=%02h exp=02", d); end
    @(negedge CLK);
    rd(8'hB4, d);
    n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL hi_dec got=%02h exp=01", d); end
    wr(8'hB2, 8'h00);
  endtask

  task automatic test_button;
    logic [7:0] d;
    wr(8'hB2, 8'h04);
    BUTTONS = 4'b0001;
    @(negedge CLK);
    rd(8'h9A, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL btn_clk1 got=%02h exp=00", d); end
    @(negedge CLK);
    rd(8'h9A, d);
    n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL btn_sync got=%02h exp=01", d); end
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h04) begin n_fail++; $display("FAIL btn_clk2 got=%02h exp=04", d); end
    @(negedge CLK);
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h14) begin n_fail++; $display("FAIL btn_pending got=%02h exp=14", d); end
    n_checks++; if (INT_CU !== 1'b0) begin n_fail++; $display("FAIL btn_int_early got=%0b exp=0", INT_CU); end
    @(negedge CLK);
    n_checks++; if (INT_CU !== 1'b1) begin n_fail++; $display("FAIL btn_int got=%0b exp=1", INT_CU); end
    wr(8'hB3, 8'h02);
    repeat (3) @(negedge CLK);
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h04) begin n_fail++; $display("FAIL btn_held got=%02h exp=04", d); end
    n_checks++; if (INT_CU !== 1'b0) begin n_fail++; $display("FAIL btn_held_int got=%0b exp=0", INT_CU); end
    BUTTONS = 4'b0000;
    repeat (4) @(negedge CLK);
    BUTTONS = 4'b0001;
    repeat (4) @(negedge CLK);
    n_checks++; if (INT_CU !== 1'b1) begin n_fail++; $display("FAIL btn_again got=%0b exp=1", INT_CU); end
    wr(8'hB2, 8'h00);
    @(negedge CLK);
    n_checks++; if (INT_CU !== 1'b0) begin n_fail++; $display("FAIL btn_masked got=%0b exp=0", INT_CU); end
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h10) begin n_fail++; $display("FAIL btn_latched got=%02h exp=10", d); end
    BUTTONS = 4'b0000;
  endtask

  task automatic test_reset_midcount;
    logic [7:0] d;
    wr(8'hB0, 8'h03);
    wr(8'hB1, 8'h00);
    wr(8'hB2, 8'h03);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    rd(8'hB4, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_cnt got=%02h exp=00", d); end
    n_checks++; if (LEDS !== 8'h00) begin n_fail++; $display("FAIL rst_leds got=%02h exp=00", LEDS); end
    repeat (8) @(negedge CLK);
    rd(8'hB2, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_status got=%02h exp=00", d); end
    n_checks++; if (INT_CU !== 1'b0) begin n_fail++; $display("FAIL rst_int got=%0b exp=0", INT_CU); end
  endtask

  initial begin
    RESET = 1'b1; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    SWITCHES = 8'h00; BUTTONS = 4'h0;
    test_reset;
    test_port_decode;
    test_read_mux;
    test_timer;
    test_timer_ack;
    test_hi_on_tick;
    test_button;
    test_reset_midcount;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
